// File: rtl/keypad_entry_buffer.sv
`default_nettype none
// ============================================================================
// Module      : keypad_entry_buffer
// Description : Captures hex keypad codes on the scanner done strobe, builds a
//               4-digit hex entry, commits it on the enter key, clears it on
//               the clear key, and shows it on a multiplexed active-low
//               7-segment display.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_entry_buffer #(
  parameter int         REFRESH_CNT = 100_000 - 1,
  parameter logic [3:0] CLR_KEY     = 4'hC,
  parameter logic [3:0] ENT_KEY     = 4'hE
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [3:0]  i_Num,
  input  logic        i_fDone,
  output logic [15:0] o_Value,
  output logic        o_fValid,
  output logic [2:0]  o_Count,
  output logic [6:0]  o_Seg,
  output logic [3:0]  o_Digit
);

  localparam int c_REF_W = (REFRESH_CNT > 0) ? $clog2(REFRESH_CNT + 1) : 1;
  localparam logic [c_REF_W-1:0] c_REF_MAX = c_REF_W'(REFRESH_CNT);
  localparam logic [2:0] c_FULL = 3'd4;
  localparam logic [6:0] c_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_DECODE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_decode;
  logic                 w_rise;
  logic                 r_done_d;
  logic [15:0]          r_buffer;
  logic [2:0]           r_count;
  logic [15:0]          r_value;
  logic                 r_valid;
  logic [c_REF_W-1:0]   r_refresh;
  logic [1:0]           r_index;
  logic [3:0]           w_nibble;
  logic                 w_blank;
  logic [6:0]           r_seg;
  logic [3:0]           r_digit;

  // Active-low {g,f,e,d,c,b,a} pattern for a hex nibble.
  function automatic logic [6:0] f_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Rising edge of the done strobe; only acted on from IDLE.
  assign w_rise = i_fDone & ~r_done_d;

  // Capture FSM state register and done-strobe delay flop.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state  <= ST_IDLE;
      r_done_d <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_done_d <= i_fDone;
    end
  end

  // Next-state logic; DECODE flags the cycle in which the key is acted on.
  always_comb begin
    w_state_next = r_state;
    w_decode     = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_rise) w_state_next = ST_WAIT;
      ST_WAIT:   w_state_next = ST_DECODE;
      ST_DECODE: begin
        w_decode     = 1'b1;
        w_state_next = ST_IDLE;
      end
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Entry buffer, digit count and committed value.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_buffer <= 16'h0000;
      r_count  <= 3'd0;
      r_value  <= 16'h0000;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_decode) begin
        if (i_Num == CLR_KEY) begin
          r_buffer <= 16'h0000;
          r_count  <= 3'd0;
        end else if (i_Num == ENT_KEY) begin
          // An empty entry is not committed and produces no pulse.
          if (r_count != 3'd0) begin
            r_value  <= r_buffer;
            r_valid  <= 1'b1;
            r_buffer <= 16'h0000;
            r_count  <= 3'd0;
          end
        end else if (r_count < c_FULL) begin
          r_buffer <= {r_buffer[11:0], i_Num};
          r_count  <= r_count + 3'd1;
        end
      end
    end
  end

  // Refresh counter and digit index for the display multiplexer.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_refresh <= '0;
      r_index   <= 2'd0;
    end else if (r_refresh == c_REF_MAX) begin
      r_refresh <= '0;
      r_index   <= r_index + 2'd1;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  // Nibble selection; digits at or beyond the count stay dark.
  always_comb begin
    w_nibble = r_buffer[3:0];
    case (r_index)
      2'd0:    w_nibble = r_buffer[3:0];
      2'd1:    w_nibble = r_buffer[7:4];
      2'd2:    w_nibble = r_buffer[11:8];
      default: w_nibble = r_buffer[15:12];
    endcase
    w_blank = ({1'b0, r_index} >= r_count);
  end

  // Registered segment and digit-enable drivers.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_seg   <= c_BLANK;
      r_digit <= 4'b1110;
    end else begin
      r_seg   <= w_blank ? c_BLANK : f_seg(w_nibble);
      r_digit <= ~(4'b0001 << r_index);
    end
  end

  assign o_Value  = r_value;
  assign o_fValid = r_valid;
  assign o_Count  = r_count;
  assign o_Seg    = r_seg;
  assign o_Digit  = r_digit;

endmodule
`default_nettype wire

// File: doc/keypad_entry_buffer.md
# keypad_entry_buffer

Downstream consumer of the hex keypad scanner. Captures each decoded key code on the scanner's done strobe. Digit keys accumulate into a 4-digit hex entry buffer; the clear key empties the buffer, and the enter key commits it as a 16-bit value. The buffer is also driven onto a 4-digit multiplexed active-low 7-segment display.

## Interface
Parameters:
- REFRESH_CNT, 100_000 - 1, clock cycles per display digit slot (1 ms at 100 MHz); bench uses 3.
- CLR_KEY, 4'hC, key code that clears the entry buffer.
- ENT_KEY, 4'hE, key code that commits the entry buffer.

Ports:
- i_Clk  in  1  system clock; the only clock.
- i_Rst  in  1  reset, asynchronous, active-high.
- i_Num  in  4  key code from scanner; valid in the cycle after i_fDone is first seen high.
- i_fDone  in  1  scanner done strobe; a rising edge marks a new key.
- o_Value  out  16  last committed entry; reset 16'h0000.
- o_fValid  out  1  one-cycle pulse when o_Value updates; reset 0.
- o_Count  out  3  digits currently in the buffer, 0..4; reset 0.
- o_Seg  out  7  segments {g,f,e,d,c,b,a}, active-low; reset 7'b1111111.
- o_Digit  out  4  digit enables, active-low, one-hot-zero; reset 4'b1110.

## Operation
- Capture FSM, states IDLE, WAIT, DECODE; reset state IDLE.
- IDLE: register i_fDone into a delay flop. If i_fDone=1 and the delayed copy=0 (rising edge), go to WAIT.
- WAIT: one cycle, allowing the scanner's code register to update. Go to DECODE.
- DECODE: sample i_Num and act, then return to IDLE.
  - Code equal to CLR_KEY: buffer <= 0, count <= 0.
  - Else, code equal to ENT_KEY:
    - If count>0: o_Value <= buffer, o_fValid=1 next cycle, buffer <= 0, count <= 0.
    - If count=0: no action and no pulse.
  - Otherwise the code is a digit.
    - If count<4: buffer <= {buffer[11:0], code}, count <= count+1.
    - If count=4 (full): the digit is discarded and the buffer is unchanged.
- Rising edges of i_fDone during WAIT or DECODE are ignored. The scanner cannot produce them that fast. The edge-detect flop keeps updating in every state.
- Held key: the scanner re-strobes roughly every 0.2 s. Each strobe is a new key; there is no repeat suppression.
- Display scanner:
  - A refresh counter runs 0..REFRESH_CNT.
  - On wrap, the 2-bit digit index advances 0->1->2->3->0.
  - Index i drives o_Digit bit i low (index 0 is the rightmost digit) and shows buffer nibble i.
  - If i >= count, the digit is blank (7'b1111111), so unused leading digits stay dark.
- Segment encoding (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Asynchronous reset mid-operation: FSM to IDLE, edge flop 0, buffer 0, count 0, o_Value 0, o_fValid 0, refresh counter 0, index 0. Any pending key is lost.

## Timing
- Edge of i_fDone seen at clock edge N: WAIT at N+1, DECODE at N+2. Buffer, count, and o_Value update at N+3.
- o_fValid is high during the cycle after the N+3 edge only.
- o_Seg/o_Digit are registered and change one cycle after the index or buffer changes.
- Each digit is held REFRESH_CNT+1 cycles; the full frame is 4*(REFRESH_CNT+1) cycles.
- o_Count reflects the count register directly.

## Test plan
- Reset then idle: o_Value=0, o_fValid=0, o_Count=0, o_Seg=7'h7F, o_Digit cycles 1110->1101->1011->0111 every 4 cycles (REFRESH_CNT=3).
- Keys 1,2,3,4 then E -> o_Count steps 1..4. o_fValid pulses once for one cycle, o_Value=16'h1234, o_Count returns to 0.
- Keys A,B,C -> after A,B o_Count=2 with digits showing b (0000011) at index 0 and A (0001000) at index 1. C clears: o_Count=0, all digits blank, o_Value unchanged.
- Keys 5,6,7,8,9 then E -> 9 is discarded, o_Value=16'h5678.
- E with empty buffer -> no o_fValid pulse and o_Value holds its previous value. i_fDone held high for 3 cycles -> exactly one capture.
- Key 7, then i_Rst asserted asynchronously between clock edges at WAIT -> all outputs at reset values immediately, and the key is not captured after reset release.
